vga_capture_monitor: RTL and testbench
======================================

VGA_CAPTURE_MONITOR -- requirements
Module: vga_capture_monitor

Interface
REQ-001 Parameter SYNC_ACTIVE_LOW, default 1: 1 means hsync/vsync are asserted low; 0 means asserted high.
REQ-002 Parameters H_TOTAL 800, H_SYNC 96, H_ACT_START 144, H_ACT 640: horizontal timing in pixel ticks, counted from the hsync assertion edge.
REQ-003 Parameters V_TOTAL 525, V_SYNC 2, V_ACT_START 34, V_ACT 480: vertical timing in lines, counted from the first line boundary after the vsync assertion edge.
REQ-004 clk  input  1  system clock (100 MHz); sole clock; every register uses its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 pix_en  input  1  one-clk pixel strobe (25 MHz, 1-in-4); inputs are sampled only on cycles where it is high.
REQ-007 hsync, vsync  input  1 each  incoming sync lines.
REQ-008 rgb  input  4  incoming pixel data.
REQ-009 locked  output  1  high while timing is verified.
REQ-010 cap_valid  output  1  one-clk pulse: cap_x, cap_y and cap_rgb hold a captured active pixel.
REQ-011 cap_x, cap_y  output  10 each  recovered pixel coordinates.
REQ-012 cap_rgb  output  4  captured pixel.
REQ-013 frame_done  output  1  one-clk pulse at frame end.
REQ-014 frame_sum  output  16  sum of active-pixel rgb for the last complete frame.
REQ-015 err_cnt  output  8  count of lock losses; saturates at 255.

Function
REQ-016 Definitions: a tick is a clk cycle with pix_en=1. A sync is asserted when it equals the level set by SYNC_ACTIVE_LOW. An assertion edge is a tick where the sync is asserted and its previous tick sample was not.
REQ-017 h_cnt (10 bit): cleared to 0 on an hsync assertion edge; otherwise increments each tick; saturates at 1023.
REQ-018 hsync width is measured as the number of ticks that hsync stays asserted after its assertion edge.
REQ-019 A line is good when it is closed by the next hsync edge with h_cnt = H_TOTAL-1 and its measured width = H_SYNC; anything else makes the line bad.
REQ-020 A line that reaches h_cnt saturation (1023) is bad, with no hsync edge required.
REQ-021 A vsync assertion edge arms a flag; the next hsync edge clears v_cnt to 0 and clears the flag; any other hsync edge increments v_cnt.
REQ-022 A frame is good when every line in it is good, v_cnt = V_TOTAL-1 at the next vsync-armed boundary, and vsync stayed asserted for exactly V_SYNC line boundaries.
REQ-023 FSM states are SEARCH, ACQUIRE and LOCKED; the reset state is SEARCH.
REQ-024 SEARCH -> ACQUIRE on the first vsync-armed boundary; good_cnt is set to 0.
REQ-025 In ACQUIRE, each frame boundary: a good frame increments good_cnt; a bad frame clears good_cnt to 0.
REQ-026 ACQUIRE -> LOCKED on the boundary where good_cnt reaches 2.
REQ-027 LOCKED -> SEARCH on the clk after any bad line or bad frame is detected; err_cnt increments (saturating).
REQ-028 locked is 1 exactly while the state is LOCKED; it drops on the same clk as the LOCKED -> SEARCH transition.
REQ-029 Active region: LOCKED and H_ACT_START <= h_cnt < H_ACT_START+H_ACT and V_ACT_START <= v_cnt < V_ACT_START+V_ACT.
REQ-030 On a tick inside the active region, on the next clk: cap_valid=1, cap_x = h_cnt-H_ACT_START, cap_y = v_cnt-V_ACT_START, cap_rgb = rgb sample. Latency is 1 clk.
REQ-031 cap_valid is 0 on all other cycles; cap_x, cap_y and cap_rgb hold their values when cap_valid is 0.
REQ-032 The accumulator adds zero-extended rgb for each active pixel and wraps modulo 2^16.
REQ-033 At each frame boundary while LOCKED: frame_sum is loaded with the accumulator, frame_done pulses for 1 clk, and the accumulator clears. A vsync-armed boundary that also contains an active pixel includes that pixel in the new frame.
REQ-034 A frame that breaks lock does not update frame_sum and does not pulse frame_done; the accumulator clears.
REQ-035 Simultaneous hsync and vsync assertion edges on the same tick: the hsync edge is processed first and the vsync flag is armed for the following hsync edge.

Reset
REQ-036 When reset=0, all outputs go to 0 asynchronously: locked, cap_valid, cap_x, cap_y, cap_rgb, frame_done, frame_sum, err_cnt. The FSM goes to SEARCH and all counters and sync history registers clear.
REQ-037 Sync history resets to the deasserted level, so a sync input held asserted through reset release produces an assertion edge on the first tick.
REQ-038 Reset asserted mid-frame discards the frame in progress; reacquisition takes at least 2 full good frames.

Verification
REQ-039 Reset released, standard 640x480 stream with rgb = x[3:0]: locked=1 within 3 frames; cap_x and cap_y match the generator coordinates; exactly 307200 cap_valid pulses per frame.
REQ-040 Constant rgb = 4'hF: frame_sum = (307200*15) mod 65536 = 20480; frame_done pulses once per frame.
REQ-041 Locked stream, one line shortened to 799 ticks: locked drops within 1 clk after that hsync edge; err_cnt = 1; that frame produces no frame_done.
REQ-042 hsync held deasserted after lock: h_cnt saturates at 1023; lock is lost; locked=0.
REQ-043 SYNC_ACTIVE_LOW=0 with inverted syncs: same results as REQ-039.
REQ-044 reset pulsed low mid-frame: all outputs 0 immediately; relock after 2 good frames.

Source files
------------

// File: rtl/vga_capture_monitor_if.sv
// rtl/vga_capture_monitor_if.sv - video input and capture result bundle for vga_capture_monitor
interface vga_capture_monitor_if;
  logic       pix_en;
  logic       hsync;
  logic       vsync;
  logic [3:0] rgb;
  logic       locked;
  logic       cap_valid;
  logic [9:0] cap_x;
  logic [9:0] cap_y;
  logic [3:0] cap_rgb;
  logic       frame_done;
  logic [15:0] frame_sum;
  logic [7:0] err_cnt;

  // video source side
  modport master (
    output pix_en, hsync, vsync, rgb,
    input  locked, cap_valid, cap_x, cap_y, cap_rgb, frame_done, frame_sum, err_cnt
  );

  // capture monitor side
  modport slave (
    input  pix_en, hsync, vsync, rgb,
    output locked, cap_valid, cap_x, cap_y, cap_rgb, frame_done, frame_sum, err_cnt
  );
endinterface

// File: rtl/vga_capture_monitor.sv
// rtl/vga_capture_monitor.sv - VGA timing lock, pixel capture and per-frame rgb sum
module vga_capture_monitor #(
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_ACT_START = 144,
  parameter int H_ACT       = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_ACT_START = 34,
  parameter int V_ACT       = 480
) (
  input  logic                  clk,
  input  logic                  reset,
  vga_capture_monitor_if.slave  vif
);

  localparam logic [9:0] CNT_MAX  = 10'h3ff;
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
  localparam logic [9:0] H_A0     = 10'(H_ACT_START);
  localparam logic [9:0] H_A1     = 10'(H_ACT_START + H_ACT);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);
  localparam logic [9:0] V_A0     = 10'(V_ACT_START);
  localparam logic [9:0] V_A1     = 10'(V_ACT_START + V_ACT);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  state_t      state_q, state_d;
  logic [1:0]  good_cnt_q, good_cnt_d;
  logic        hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic [9:0]  h_cnt_q, h_cnt_d, hw_cnt_q, hw_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d, vw_cnt_q, vw_cnt_d, vw_last_q, vw_last_d;
  logic        v_arm_q, v_arm_d, frame_bad_q, frame_bad_d;
  logic [15:0] acc_q, acc_d, frame_sum_q, frame_sum_d;
  logic        locked_q, locked_d, cap_valid_q, cap_valid_d, frame_done_q, frame_done_d;
  logic [9:0]  cap_x_q, cap_x_d, cap_y_q, cap_y_d;
  logic [3:0]  cap_rgb_q, cap_rgb_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic hs_act, vs_act, hs_edge, vs_edge, boundary, line_bad, frame_bad, active;

  // Sync edge detection, line/frame qualification, lock FSM and capture datapath
  always_comb begin
    hs_act   = SYNC_ACTIVE_LOW ? ~vif.hsync : vif.hsync;
    vs_act   = SYNC_ACTIVE_LOW ? ~vif.vsync : vif.vsync;
    hs_edge  = vif.pix_en & hs_act & ~hs_prev_q;
    vs_edge  = vif.pix_en & vs_act & ~vs_prev_q;
    // the armed flag is consumed by this hsync edge before any same-tick vsync edge re-arms it
    boundary = hs_edge & v_arm_q;
    // a line closes bad on a wrong length or sync width, or when it runs into saturation
    line_bad = (hs_edge & ((h_cnt_q != H_LAST) | (hw_cnt_q != H_SYNC_W)))
             | (vif.pix_en & ~hs_edge & (h_cnt_q == CNT_MAX - 10'd1));
    // vw_last holds the width of the vsync pulse that opened the frame now closing
    frame_bad = boundary & (frame_bad_q | line_bad | (v_cnt_q != V_LAST) | (vw_last_q != V_SYNC_W));

    state_d      = state_q;
    good_cnt_d   = good_cnt_q;
    hs_prev_d    = hs_prev_q;
    vs_prev_d    = vs_prev_q;
    h_cnt_d      = h_cnt_q;
    hw_cnt_d     = hw_cnt_q;
    v_cnt_d      = v_cnt_q;
    vw_cnt_d     = vw_cnt_q;
    vw_last_d    = vw_last_q;
    v_arm_d      = v_arm_q;
    frame_bad_d  = frame_bad_q;
    acc_d        = acc_q;
    frame_sum_d  = frame_sum_q;
    cap_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    cap_x_d      = cap_x_q;
    cap_y_d      = cap_y_q;
    cap_rgb_d    = cap_rgb_q;
    err_cnt_d    = err_cnt_q;
    active       = 1'b0;

    if (vif.pix_en) begin
      hs_prev_d = hs_act;
      vs_prev_d = vs_act;

      if (hs_edge)                h_cnt_d = 10'd0;
      else if (h_cnt_q != CNT_MAX) h_cnt_d = h_cnt_q + 10'd1;

      if (hs_edge)                                    hw_cnt_d = 10'd1;
      else if (hs_act && hw_cnt_q != CNT_MAX)         hw_cnt_d = hw_cnt_q + 10'd1;

      if (hs_edge) begin
        if (v_arm_q)                v_cnt_d = 10'd0;
        else if (v_cnt_q != CNT_MAX) v_cnt_d = v_cnt_q + 10'd1;
      end
      v_arm_d = vs_edge | (v_arm_q & ~hs_edge);

      if (vs_edge) begin
        vw_last_d = vw_cnt_q;
        vw_cnt_d  = hs_edge ? 10'd1 : 10'd0;
      end else if (hs_edge && vs_act && vw_cnt_q != CNT_MAX) begin
        vw_cnt_d  = vw_cnt_q + 10'd1;
      end

      frame_bad_d = boundary ? 1'b0 : (frame_bad_q | line_bad);

      active = (state_q == LOCKED) && (h_cnt_d >= H_A0) && (h_cnt_d < H_A1)
            && (v_cnt_d >= V_A0) && (v_cnt_d < V_A1);
      if (active) begin
        cap_valid_d = 1'b1;
        cap_x_d     = h_cnt_d - H_A0;
        cap_y_d     = v_cnt_d - V_A0;
        cap_rgb_d   = vif.rgb;
      end

      acc_d = 16'd0;
      case (state_q)
        SEARCH: begin
          if (boundary) begin
            state_d    = ACQUIRE;
            good_cnt_d = 2'd0;
          end
        end
        ACQUIRE: begin
          if (boundary) begin
            if (frame_bad) begin
              good_cnt_d = 2'd0;
            end else if (good_cnt_q == 2'd1) begin
              good_cnt_d = 2'd2;
              state_d    = LOCKED;
            end else begin
              good_cnt_d = good_cnt_q + 2'd1;
            end
          end
        end
        default: begin
          if (line_bad || frame_bad) begin
            state_d   = SEARCH;
            err_cnt_d = (err_cnt_q == 8'hff) ? err_cnt_q : err_cnt_q + 8'd1;
          end else if (boundary) begin
            frame_sum_d  = acc_q;
            frame_done_d = 1'b1;
            acc_d        = active ? {12'd0, vif.rgb} : 16'd0;
          end else begin
            acc_d = active ? acc_q + {12'd0, vif.rgb} : acc_q;
          end
        end
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= SEARCH;
      good_cnt_q   <= 2'd0;
      hs_prev_q    <= 1'b0;
      vs_prev_q    <= 1'b0;
      h_cnt_q      <= 10'd0;
      hw_cnt_q     <= 10'd0;
      v_cnt_q      <= 10'd0;
      vw_cnt_q     <= 10'd0;
      vw_last_q    <= 10'd0;
      v_arm_q      <= 1'b0;
      frame_bad_q  <= 1'b0;
      acc_q        <= 16'd0;
      frame_sum_q  <= 16'd0;
      locked_q     <= 1'b0;
      cap_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      cap_x_q      <= 10'd0;
      cap_y_q      <= 10'd0;
      cap_rgb_q    <= 4'd0;
      err_cnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      good_cnt_q   <= good_cnt_d;
      hs_prev_q    <= hs_prev_d;
      vs_prev_q    <= vs_prev_d;
      h_cnt_q      <= h_cnt_d;
      hw_cnt_q     <= hw_cnt_d;
      v_cnt_q      <= v_cnt_d;
      vw_cnt_q     <= vw_cnt_d;
      vw_last_q    <= vw_last_d;
      v_arm_q      <= v_arm_d;
      frame_bad_q  <= frame_bad_d;
      acc_q        <= acc_d;
      frame_sum_q  <= frame_sum_d;
      locked_q     <= locked_d;
      cap_valid_q  <= cap_valid_d;
      frame_done_q <= frame_done_d;
      cap_x_q      <= cap_x_d;
      cap_y_q      <= cap_y_d;
      cap_rgb_q    <= cap_rgb_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign vif.locked     = locked_q;
  assign vif.cap_valid  = cap_valid_q;
  assign vif.cap_x      = cap_x_q;
  assign vif.cap_y      = cap_y_q;
  assign vif.cap_rgb    = cap_rgb_q;
  assign vif.frame_done = frame_done_q;
  assign vif.frame_sum  = frame_sum_q;
  assign vif.err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_vga_capture_monitor.sv
// tb/tb_vga_capture_monitor.sv - scoreboard bench for vga_capture_monitor with reduced timing
module tb_vga_capture_monitor;
  localparam int HT = 24, HS = 3, HAS = 6, HA = 12;
  localparam int VT = 10, VS = 2, VAS = 3, VA = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  vga_capture_monitor_if ia();
  vga_capture_monitor_if ib();

  vga_capture_monitor #(.SYNC_ACTIVE_LOW(1'b1), .H_TOTAL(HT), .H_SYNC(HS), .H_ACT_START(HAS), .H_ACT(HA),
                        .V_TOTAL(VT), .V_SYNC(VS), .V_ACT_START(VAS), .V_ACT(VA))
    dut_a (.clk(clk), .reset(reset), .vif(ia));

  vga_capture_monitor #(.SYNC_ACTIVE_LOW(1'b0), .H_TOTAL(HT), .H_SYNC(HS), .H_ACT_START(HAS), .H_ACT(HA),
                        .V_TOTAL(VT), .V_SYNC(VS), .V_ACT_START(VAS), .V_ACT(VA))
    dut_b (.clk(clk), .reset(reset), .vif(ib));

  int total = 0;
  int bad = 0;
  logic [23:0] cap_qa[$], cap_qb[$];
  logic [15:0] sum_qa[$], sum_qb[$];
  bit          prev_full = 1'b0;
  logic [15:0] prev_sum = 16'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // one pixel tick: dut_a sees active-low syncs, dut_b the inverted (active-high) copy
  task automatic tick(input bit hs, input bit vs, input logic [3:0] c);
    ia.hsync = ~hs; ia.vsync = ~vs; ib.hsync = hs; ib.vsync = vs;
    ia.rgb = c; ib.rgb = c;
    ia.pix_en = 1'b1; ib.pix_en = 1'b1;
    @(negedge clk);
    ia.pix_en = 1'b0; ib.pix_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_state(input string tag, input logic lk, input logic [7:0] err);
    chk({tag, "_a_locked"}, ia.locked, lk);
    chk({tag, "_b_locked"}, ib.locked, lk);
    chk({tag, "_a_err"}, ia.err_cnt, err);
    chk({tag, "_b_err"}, ib.err_cnt, err);
  endtask

  // generator line 0 carries the vsync edge; monitor v_cnt of line l is l-1 (line 0 ends the prior frame)
  task automatic frame(input int nlines, input bit lk_in, input int short_l, input bit flat);
    logic [15:0] sum;
    logic [3:0]  c;
    bit          lk, full;
    int          len, v;
    sum = 16'd0; lk = lk_in; full = lk_in;
    for (int l = 0; l < nlines; l++) begin
      len = (l == short_l) ? HT - 1 : HT;
      v   = (l == 0) ? VT - 1 : l - 1;
      for (int h = 0; h < len; h++) begin
        c = flat ? 4'hF : 4'(h - HAS);
        if (l == 1 && h == 0 && prev_full) begin
          sum_qa.push_back(prev_sum);
          sum_qb.push_back(prev_sum);
          prev_full = 1'b0;
        end
        if (lk && h >= HAS && h < HAS + HA && v >= VAS && v < VAS + VA) begin
          cap_qa.push_back({10'(h - HAS), 10'(v - VAS), c});
          cap_qb.push_back({10'(h - HAS), 10'(v - VAS), c});
          sum = sum + {12'd0, c};
        end
        tick(h < HS, l < VS, c);
        if (short_l >= 0 && l == short_l + 1 && h == 0) chk_state("drop", 1'b0, 8'd1);
      end
      if (l == short_l) begin
        lk = 1'b0;
        full = 1'b0;
      end
    end
    prev_full = full && (nlines == VT);
    prev_sum  = sum;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 4'd0);
    prev_full = 1'b0;
  endtask

  // scoreboard monitor: every capture or frame_done pops the next expected entry
  always @(negedge clk) begin
    if (ia.cap_valid) begin
      if (cap_qa.size() == 0) begin
        total++; bad++;
        $display("FAIL a_cap_extra: got x=%0d y=%0d expected no capture", ia.cap_x, ia.cap_y);
      end else chk("a_cap", {ia.cap_x, ia.cap_y, ia.cap_rgb}, cap_qa.pop_front());
    end
    if (ib.cap_valid) begin
      if (cap_qb.size() == 0) begin
        total++; bad++;
        $display("FAIL b_cap_extra: got x=%0d y=%0d expected no capture", ib.cap_x, ib.cap_y);
      end else chk("b_cap", {ib.cap_x, ib.cap_y, ib.cap_rgb}, cap_qb.pop_front());
    end
    if (ia.frame_done) begin
      if (sum_qa.size() == 0) begin
        total++; bad++;
        $display("FAIL a_done_extra: got sum=%0d expected no frame_done", ia.frame_sum);
      end else chk("a_frame_sum", ia.frame_sum, sum_qa.pop_front());
    end
    if (ib.frame_done) begin
      if (sum_qb.size() == 0) begin
        total++; bad++;
        $display("FAIL b_done_extra: got sum=%0d expected no frame_done", ib.frame_sum);
      end else chk("b_frame_sum", ib.frame_sum, sum_qb.pop_front());
    end
  end

  initial begin
    ia.pix_en = 1'b0; ia.hsync = 1'b1; ia.vsync = 1'b1; ia.rgb = 4'd0;
    ib.pix_en = 1'b0; ib.hsync = 1'b0; ib.vsync = 1'b0; ib.rgb = 4'd0;
    repeat (3) @(negedge clk);
    chk_state("reset", 1'b0, 8'd0);
    chk("reset_a_cap_valid", ia.cap_valid, 0);
    chk("reset_b_frame_sum", ib.frame_sum, 0);
    reset = 1'b1;
    @(negedge clk);

    frame(VT, 1'b0, -1, 1'b0);
    frame(VT, 1'b0, -1, 1'b0);
    chk_state("acquire", 1'b0, 8'd0);
    frame(VT, 1'b1, -1, 1'b0);
    chk_state("locked", 1'b1, 8'd0);
    frame(VT, 1'b1, -1, 1'b0);
    frame(VT, 1'b1, -1, 1'b1);
    frame(VT, 1'b1, 5, 1'b0);
    frame(VT, 1'b0, -1, 1'b0);
    frame(VT, 1'b0, -1, 1'b0);
    chk_state("reacq", 1'b0, 8'd1);
    frame(VT, 1'b1, -1, 1'b0);
    chk_state("relock", 1'b1, 8'd1);

    idle(1010);
    chk_state("sat", 1'b0, 8'd2);

    frame(VT, 1'b0, -1, 1'b0);
    frame(VT, 1'b0, -1, 1'b0);
    frame(6, 1'b1, -1, 1'b0);
    chk_state("pre_rst", 1'b1, 8'd2);

    reset = 1'b0;
    #1;
    chk_state("mid_rst", 1'b0, 8'd0);
    chk("mid_rst_a_sum", ia.frame_sum, 0);
    chk("mid_rst_b_sum", ib.frame_sum, 0);
    chk("mid_rst_a_capx", ia.cap_x, 0);
    chk("mid_rst_b_caprgb", ib.cap_rgb, 0);
    prev_full = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    frame(VT, 1'b0, -1, 1'b0);
    frame(VT, 1'b0, -1, 1'b0);
    chk_state("post_rst_acq", 1'b0, 8'd0);
    frame(VT, 1'b1, -1, 1'b0);
    frame(2, 1'b1, -1, 1'b0);
    chk_state("post_rst_lock", 1'b1, 8'd0);
    repeat (4) @(negedge clk);

    chk("a_cap_left", cap_qa.size(), 0);
    chk("b_cap_left", cap_qb.size(), 0);
    chk("a_sum_left", sum_qa.size(), 0);
    chk("b_sum_left", sum_qb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
